bcd_serial_tx: RTL



---
 rtl/bcd_serial_tx_if.sv | 11 +
 rtl/bcd_serial_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_tx_if.sv
// Digit input bus of the serial BCD transmitter.
// valid/ready: a digit transfers on a rising clock edge where DIN_VALID and
// DIN_READY are both high; DIN is ignored whenever DIN_VALID is low.
interface bcd_serial_tx_if;
  logic [3:0] DIN;
  logic       DIN_VALID;
  logic       DIN_READY;

  modport master (output DIN, output DIN_VALID, input DIN_READY);
  modport slave  (input DIN, input DIN_VALID, output DIN_READY);
endinterface

// File: rtl/bcd_serial_tx.sv
// Serial BCD digit transmitter: FIFO-buffered digits are shifted onto LINEA
// one bit per clock, with FRAME/LAST markers and an optional inter-digit gap.
module bcd_serial_tx #(
  parameter int DEPTH     = 4,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic           clock,
  input  logic           RESET_G,
  bcd_serial_tx_if.slave bus,
  input  logic           ERR_CLR,
  output logic           LINEA,
  output logic           FRAME,
  output logic           LAST,
  output logic           BUSY,
  output logic           ERR,
  output logic [CW-1:0]  COUNT,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0]    GAP_C   = 4'(GAP);

  state_t          state_q, state_d;
  logic [3:0]      mem_q [DEPTH];
  logic [3:0]      mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      cur_q, cur_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [3:0]      gapcnt_q, gapcnt_d;
  logic            linea_q, linea_d;
  logic            frame_q, frame_d;
  logic            last_q, last_d;
  logic            err_q, err_d;

  logic            ready, accept, push, reject, start;
  logic [3:0]      head;

  // Selects the k-th wire bit of a digit (k = 0 is sent first).
  function automatic logic pick(input logic [3:0] d, input logic [1:0] k);
    pick = MSB_FIRST ? d[2'd3 - k] : d[k];
  endfunction

  // No bypass: a pop in the same cycle never makes a full FIFO ready.
  assign ready  = ~RESET_G & (count_q < DEPTH_C);
  assign accept = bus.DIN_VALID & ready;
  assign push   = accept & (bus.DIN <= 4'd9);
  assign reject = accept & (bus.DIN > 4'd9);
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    linea_d  = 1'b0;
    frame_d  = 1'b0;
    last_d   = 1'b0;
    start    = 1'b0;

    unique case (state_q)
      ST_IDLE: start = (count_q != '0);
      ST_SHIFT: begin
        if (bitcnt_q != 3'd4) begin
          linea_d  = pick(cur_q, bitcnt_q[1:0]);
          frame_d  = 1'b1;
          last_d   = (bitcnt_q == 3'd3);
          bitcnt_d = bitcnt_q + 3'd1;
        end else if ((GAP_C == 4'd0) && (count_q != '0)) begin
          start = 1'b1;
        end else if (GAP_C != 4'd0) begin
          state_d  = ST_GAP;
          gapcnt_d = 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        // The cycle that leaves SHIFT is the first gap cycle.
        if (gapcnt_q != GAP_C) begin
          gapcnt_d = gapcnt_q + 4'd1;
        end else begin
          start   = (count_q != '0);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      cur_d    = head;
      linea_d  = pick(head, 2'd0);
      frame_d  = 1'b1;
      bitcnt_d = 3'd1;
      state_d  = ST_SHIFT;
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.DIN;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (start) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(start);

    // A reject in the same cycle as ERR_CLR keeps the flag set.
    err_d = reject | (err_q & ~ERR_CLR);
  end

  always_ff @(posedge clock) begin
    if (RESET_G) begin
      state_q  <= ST_IDLE;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cur_q    <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      linea_q  <= 1'b0;
      frame_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cur_q    <= cur_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      linea_q  <= linea_d;
      frame_q  <= frame_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign bus.DIN_READY = ready;
  assign LINEA         = linea_q;
  assign FRAME         = frame_q;
  assign LAST          = last_q;
  assign ERR           = err_q;
  assign COUNT         = count_q;
  assign BUSY          = (count_q != '0) | (state_q != ST_IDLE);
  assign state_dbg     = state_q;

endmodule
